// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Parallel word handshake into the UART transmit framer.
//
// Signals:
//   tx_data   word to transmit (DWIDTH bits), producer -> framer
//   tx_valid  tx_data is valid, producer -> framer
//   tx_ready  framer can accept a word, framer -> producer
//
// Modports:
//   master  producer side (drives tx_data/tx_valid)
//   slave   framer side   (drives tx_ready)
// -----------------------------------------------------------------------------
interface uart_tx_if #(
    parameter int DWIDTH = 8
);
    logic [DWIDTH-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface : uart_tx_if

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmit framer/serializer. Accepts a parallel word over a valid/ready
// handshake, holds it on frame_data for the downstream parity stage, and
// shifts out start bit, data bits LSB-first, an optional parity bit (taken
// from par_bit) and the stop bit(s) on tx_out. Each serial bit lasts
// CLKS_PER_BIT clocks, timed by an internal prescaler.
//
// Parameters:
//   DWIDTH        data word width (>= 1)
//   CLKS_PER_BIT  clk cycles per serial bit (>= 1)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   bus         uart_tx_if.slave: tx_data, tx_valid in; tx_ready out
//   par_en      frame carries a parity bit (sampled at accept)
//   par_bit     parity bit from the parity stage, computed over frame_data
//   frame_data  latched word, stable for the whole frame
//   tx_out      serial line, idles high
//   busy        frame in progress
//
// Build option:
//   UART_TX_STOP2_EN  when defined, each frame ends with two stop bits.
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int DWIDTH       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_if.slave          bus,
    input  logic              par_en,
    input  logic              par_bit,
    output logic [DWIDTH-1:0] frame_data,
    output logic              tx_out,
    output logic              busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DWIDTH - 1);
    localparam logic [BW-1:0] IDX_ONE  = BW'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     idx_q, idx_d;
    logic              par_en_q, par_en_d;
    logic              ready_q, ready_d;
    logic [DWIDTH-1:0] frame_data_d;
    logic              tx_out_d;
    logic              busy_d;

    logic              wrap;
    logic              stop_last;

    // Prescaler terminal count: the only edge on which state and line change.
    assign wrap = (cnt_q == CNT_MAX);

    // In STOP the bit index is reused to count stop bits.
`ifdef UART_TX_STOP2_EN
    assign stop_last = (idx_q != '0);
`else
    assign stop_last = 1'b1;
`endif

    assign bus.tx_ready = ready_q;

    // -------------------------------------------------------------------------
    // Next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a hold default first so no path infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        par_en_d     = par_en_q;
        ready_d      = ready_q;
        frame_data_d = frame_data;
        tx_out_d     = tx_out;
        busy_d       = busy;

        if (state_q != IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.tx_valid && ready_q) begin
                    frame_data_d = bus.tx_data;
                    par_en_d     = par_en;
                    ready_d      = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = START;
                    tx_out_d     = 1'b0;
                    cnt_d        = '0;
                end
            end

            START: begin
                if (wrap) begin
                    state_d  = DATA;
                    idx_d    = '0;
                    tx_out_d = frame_data[0];
                end
            end

            DATA: begin
                if (wrap) begin
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (par_en_q) begin
                            state_d  = PARITY;
                            tx_out_d = par_bit;
                        end else begin
                            state_d  = STOP;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        tx_out_d = frame_data[idx_d];
                    end
                end
            end

            PARITY: begin
                if (wrap) begin
                    state_d  = STOP;
                    tx_out_d = 1'b1;
                end
            end

            STOP: begin
                if (wrap) begin
                    if (stop_last) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = IDX_ONE;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                idx_d    = '0;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                tx_out_d = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            par_en_q   <= 1'b0;
            ready_q    <= 1'b1;
            frame_data <= '0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            par_en_q   <= par_en_d;
            ready_q    <= ready_d;
            frame_data <= frame_data_d;
            tx_out     <= tx_out_d;
            busy       <= busy_d;
        end
    end

endmodule : uart_tx_frame

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
// Directed testbench for uart_tx_frame (DWIDTH=8, CLKS_PER_BIT=4).
// Each scenario task drives stimulus and compares against hand-computed
// frames. Frame images are packed with slot 0 (start bit) in bit 0.
// Build with +define+UART_TX_STOP2_EN to exercise the two-stop-bit variant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_frame;

    localparam int DW  = 8;
    localparam int CPB = 4;

`ifdef UART_TX_STOP2_EN
    localparam logic [15:0] EXP_A5_EVEN = 16'h0D4A;
    localparam logic [15:0] EXP_A5_ODD  = 16'h0F4A;
    localparam logic [15:0] EXP_3C      = 16'h0678;
    localparam logic [15:0] EXP_01      = 16'h0602;
    localparam logic [15:0] EXP_55      = 16'h06AA;
    localparam int          LEN_PAR     = 48;
    localparam int          LEN_NOPAR   = 44;
`else
    localparam logic [15:0] EXP_A5_EVEN = 16'h054A;
    localparam logic [15:0] EXP_A5_ODD  = 16'h074A;
    localparam logic [15:0] EXP_3C      = 16'h0278;
    localparam logic [15:0] EXP_01      = 16'h0202;
    localparam logic [15:0] EXP_55      = 16'h02AA;
    localparam int          LEN_PAR     = 44;
    localparam int          LEN_NOPAR   = 40;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          par_en = 1'b0;
    logic          par_bit = 1'b0;
    logic [DW-1:0] frame_data;
    logic          tx_out;
    logic          busy;

    int passed = 0;
    int total  = 0;

    uart_tx_if #(.DWIDTH(DW)) bus ();

    uart_tx_frame #(
        .DWIDTH      (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .par_en    (par_en),
        .par_bit   (par_bit),
        .frame_data(frame_data),
        .tx_out    (tx_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Present a word for one edge; returns 1 ns after that edge.
    task automatic send(input logic [DW-1:0] data, input logic pen);
        bus.tx_data  = data;
        bus.tx_valid = 1'b1;
        par_en       = pen;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    // Called 1 ns after the accept edge. Records one sample per bit slot,
    // counts cycles until tx_ready returns, and flags any glitch within a
    // slot, a busy drop, or a frame_data change.
    task automatic capture(input logic [DW-1:0] fd_exp, output logic [15:0] bits,
                           output int low_cycles, output bit stable, output bit fd_const);
        int k;
        bits       = '0;
        low_cycles = 0;
        stable     = 1'b1;
        fd_const   = 1'b1;
        while (bus.tx_ready !== 1'b1 && low_cycles < 200) begin
            k = low_cycles / CPB;
            if (k < 16) begin
                if (low_cycles % CPB == 0) bits[k] = tx_out;
                else if (tx_out !== bits[k]) stable = 1'b0;
            end
            if (busy !== 1'b1) stable = 1'b0;
            if (frame_data !== fd_exp) fd_const = 1'b0;
            @(posedge clk);
            #1;
            low_cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({tx_out, bus.tx_ready, busy} !== 3'b110)
            $display("FAIL reset_outputs: got tx_out/ready/busy=%b expected 110", {tx_out, bus.tx_ready, busy});
        else passed++;
        total++;
        if (frame_data !== 8'h00)
            $display("FAIL reset_frame_data: got %h expected 00", frame_data);
        else passed++;
    endtask

    task automatic run_frame(input string name, input logic [DW-1:0] data, input logic pen,
                             input logic pb, input logic [15:0] exp_bits, input int exp_len,
                             input bit flip_par_en);
        logic [15:0] bits;
        int          len;
        bit          stable, fd_const;
        par_bit = pb;
        send(data, pen);
        if (flip_par_en) par_en = ~pen;
        capture(data, bits, len, stable, fd_const);
        total++;
        if (bits !== exp_bits)
            $display("FAIL %s_bits: got %h expected %h", name, bits, exp_bits);
        else passed++;
        total++;
        if (len !== exp_len)
            $display("FAIL %s_length: got %0d expected %0d", name, len, exp_len);
        else passed++;
        total++;
        if (!stable || !fd_const)
            $display("FAIL %s_stability: got stable=%0d fd_const=%0d expected 1 1", name, stable, fd_const);
        else passed++;
        par_en = 1'b0;
    endtask

    task automatic test_parity_even();
        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, EXP_A5_EVEN, LEN_PAR, 1'b0);
    endtask

    task automatic test_parity_odd();
        run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, EXP_A5_ODD, LEN_PAR, 1'b0);
    endtask

    // par_en is flipped right after accept; the latched value must win.
    task automatic test_no_parity();
        run_frame("3c_nopar", 8'h3C, 1'b0, 1'b0, EXP_3C, LEN_NOPAR, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        int          len;
        bit          stable, fd_const;
        par_bit = 1'b0;
        send(8'hA5, 1'b1);
        fork
            capture(8'hA5, bits, len, stable, fd_const);
            begin
                // Slot cycle 10 of the frame: the spurious word must be ignored.
                repeat (9) @(posedge clk);
                #2;
                bus.tx_data  = 8'hFF;
                bus.tx_valid = 1'b1;
                @(posedge clk);
                #2;
                bus.tx_valid = 1'b0;
            end
        join
        total++;
        if (bits !== EXP_A5_EVEN || len !== LEN_PAR || !stable || !fd_const)
            $display("FAIL ignore_valid: got bits=%h len=%0d stable=%0d fd_const=%0d expected %h %0d 1 1",
                     bits, len, stable, fd_const, EXP_A5_EVEN, LEN_PAR);
        else passed++;
        // Now in the single tx_ready cycle: accept must start START on the next edge.
        send(8'h01, 1'b0);
        total++;
        if ({tx_out, bus.tx_ready, busy} !== 3'b001 || frame_data !== 8'h01)
            $display("FAIL b2b_start: got tx_out/ready/busy=%b frame_data=%h expected 001 01",
                     {tx_out, bus.tx_ready, busy}, frame_data);
        else passed++;
        capture(8'h01, bits, len, stable, fd_const);
        total++;
        if (bits !== EXP_01 || len !== LEN_NOPAR || !stable || !fd_const)
            $display("FAIL b2b_frame: got bits=%h len=%0d stable=%0d fd_const=%0d expected %h %0d 1 1",
                     bits, len, stable, fd_const, EXP_01, LEN_NOPAR);
        else passed++;
    endtask

    task automatic test_mid_frame_reset();
        par_bit = 1'b0;
        send(8'hA5, 1'b1);
        // Cycle 17 after accept lies inside data bit 3 (cycles 16..19); 0xA5 bit 3 = 0.
        repeat (17) @(posedge clk);
        #1;
        total++;
        if (tx_out !== 1'b0 || busy !== 1'b1)
            $display("FAIL pre_reset_bit3: got tx_out=%b busy=%b expected 0 1", tx_out, busy);
        else passed++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({tx_out, bus.tx_ready, busy} !== 3'b110 || frame_data !== 8'h00)
            $display("FAIL midframe_reset: got tx_out/ready/busy=%b frame_data=%h expected 110 00",
                     {tx_out, bus.tx_ready, busy}, frame_data);
        else passed++;
        run_frame("55_after_rst", 8'h55, 1'b0, 1'b0, EXP_55, LEN_NOPAR, 1'b0);
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        test_reset();
        test_parity_even();
        @(posedge clk); #1;
        test_parity_odd();
        @(posedge clk); #1;
        test_no_parity();
        @(posedge clk); #1;
        test_back_to_back();
        @(posedge clk); #1;
        test_mid_frame_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog: guarantees termination even if a task stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_uart_tx_frame
